// File: rtl/mem_write_buffer_ctrl.sv
// Posted-store write buffer plus load sequencer in front of memoria_compartilhada.
// Latency: a store drains one cycle after it is buffered; a load returns cpu_rvalid RD_LAT+1 cycles after accept.
// Backpressure: stores stall while the buffer is full; loads stall until the buffer and the last write pulse have cleared.
//
// Ports:
//   clock, reset                      rising-edge clock, asynchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata CPU request, held until cpu_ready
//   cpu_ready                         combinational accept for the current cycle
//   cpu_rvalid/cpu_rdata              one-cycle load return pulse; data held until the next return
//   mem_endereco/mem_indata           registered memory address / write data
//   mem_lerMem/mem_escMem             registered memory read / write enables
//   mem_output                        memory read data
//   wb_count                          occupied write-buffer entries
module mem_write_buffer_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [ADDR_W-1:0]        mem_endereco,
    output logic [DATA_W-1:0]        mem_indata,
    output logic                     mem_lerMem,
    output logic                     mem_escMem,
    input  logic [DATA_W-1:0]        mem_output,
    output logic [$clog2(DEPTH):0]   wb_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [ADDR_W-1:0]   r_endereco;
    logic [DATA_W-1:0]   r_indata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_lerMem;
    logic                r_escMem;
    logic                r_rvalid;

    logic                w_push;
    logic                w_pop;
    logic                w_ld_acc;

    // Fullness is judged on the registered count, so a pop in the same cycle
    // never frees a slot early: a store into a full buffer always waits a cycle.
    assign w_push   = ~reset & cpu_req & cpu_we & (r_count < FULL_CNT);
    assign w_pop    = (r_state == IDLE) & (r_count != '0);
    // A load only starts once every earlier store has actually reached memory,
    // including the one whose write pulse is on the bus right now.
    assign w_ld_acc = ~reset & cpu_req & ~cpu_we & (r_state == IDLE) &
                      (r_count == '0) & ~r_escMem;

    assign cpu_ready    = w_push | w_ld_acc;
    assign cpu_rvalid   = r_rvalid;
    assign cpu_rdata    = r_rdata;
    assign mem_endereco = r_endereco;
    assign mem_indata   = r_indata;
    assign mem_lerMem   = r_lerMem;
    assign mem_escMem   = r_escMem;
    assign wb_count     = r_count;

    // Entry storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_addr;
            r_fifo_data[r_wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lat_cnt  <= '0;
            r_endereco <= '0;
            r_indata   <= '0;
            r_rdata    <= '0;
            r_lerMem   <= 1'b0;
            r_escMem   <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_escMem <= 1'b0;
            r_rvalid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_endereco <= r_fifo_addr[r_rd_ptr];
                        r_indata   <= r_fifo_data[r_rd_ptr];
                        r_escMem   <= 1'b1;
                    end else if (w_ld_acc) begin
                        r_endereco <= cpu_addr;
                        r_lerMem   <= 1'b1;
                        r_lat_cnt  <= LAT_W'(RD_LAT - 1);
                        r_state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_lerMem <= 1'b0;
                        r_rdata  <= mem_output;
                        r_rvalid <= 1'b1;
                        r_state  <= RD_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                RD_RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
